newpoint_writer: RTL and testbench
==================================

# newpoint_writer

Output-side companion to `point_cal`. Captures each result record, meaning 4 inner points, 4 outer points and the delayed boundary point. Drops the pipeline warm-up records, buffers the rest in a small record FIFO, and serializes each record as 18 coordinate words on a ready/valid stream. The stream feeds the result RAM or debug UART, which replaces the bench-side file writer in hardware.

## Interface
- `WIDTH`, default 14: coordinate width, fixed point with 4 fractional bits.
- `DEPTH`, default 4: record FIFO depth, in records; power of 2, at least 2.
- `SKIP`, default 6: number of leading accepted records discarded after reset.
- `clk` in, 1: clock, rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `in_valid` in, 1: the record on the inputs is valid.
- `in_ready` out, 1: the block can accept a record.
- `new_xi` in, 4*WIDTH: inner x coordinates, `{xi3,xi2,xi1,xi0}`.
- `new_yi` in, 4*WIDTH: inner y coordinates, same packing.
- `new_xo` in, 4*WIDTH: outer x coordinates, same packing.
- `new_yo` in, 4*WIDTH: outer y coordinates, same packing.
- `xb_o` in, WIDTH: delayed boundary x.
- `yb_o` in, WIDTH: delayed boundary y.
- `out_valid` out, 1: `out_data` holds a valid word.
- `out_ready` in, 1: downstream accepts the word.
- `out_data` out, WIDTH: current coordinate word.
- `out_idx` out, 5: index of the word within its record, 0..17.
- `out_last` out, 1: high when `out_idx` is 17.
- `ovf` out, 1: sticky flag; a record was offered while `in_ready` was low.

## Operation
- A record is accepted on any rising edge where `in_valid` and `in_ready` are both high.
- Skip counter:
  - Counts accepted records from reset, saturating at `SKIP`.
  - While the count is below `SKIP`, an accepted record is discarded and only the counter increments.
  - `SKIP`=0 means no records are discarded.
- Once the skip counter reaches `SKIP`, each accepted record is written to the FIFO tail. The write pointer and count update on that edge.
- `in_ready` is `!full`. There is no pass-through when full: a pop and a push in the same cycle while full is impossible, because `in_ready` is already low.
- Serializer order, by `out_idx`:
  - 0–7: xi0, yi0, xi1, yi1, xi2, yi2, xi3, yi3.
  - 8–15: xo0, yo0, xo1, yo1, xo2, yo2, xo3, yo3.
  - 16–17: xb_o, yb_o.
- Serializer states:
  - IDLE: FIFO empty, `out_valid`=0. Moves to SEND when the count becomes nonzero.
  - SEND: `out_valid`=1, and `out_data` is the head record muxed by the index register.
- SEND behaviour on each handshake (`out_valid & out_ready`):
  - If index < 17, the index increments.
  - If index = 17, the index returns to 0 and the head record is popped. The state stays in SEND if the count after the pop is nonzero, otherwise it returns to IDLE.
- A push and a pop on the same edge leave the count unchanged; both pointers advance and wrap modulo `DEPTH`.
- `ovf` sets on `in_valid & !in_ready` and clears only on reset.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `ovf`=0.
  - FIFO empty, skip count 0.
- Reset asserted mid-record discards all buffered records and the partial word position. After release, the skip counter restarts, so the next `SKIP` records are dropped again.
- Latency: a record pushed into an empty FIFO at edge N presents word 0 with `out_valid`=1 in the cycle after edge N.
- Throughput:
  - One word per cycle while `out_ready`=1.
  - 18 cycles per record.
  - No bubble between consecutive buffered records: word 0 of the next record follows word 17 of the previous one directly.
- Stability: while `out_valid & !out_ready`, `out_data`, `out_idx` and `out_last` hold.
- `in_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop of word 17.

## Configuration
- `NEWPOINT_ROUND_EN` defined:
  - Every output word is converted to integer pixels with round-half-up: `(v + 8) >> 4`.
  - The result saturates at `2^(WIDTH-4)-1`, is zero-extended to `WIDTH`, and the sum is computed at `WIDTH+1` bits.
- Undefined: words pass through as raw `WIDTH`-bit fixed point.

## Test plan
- Skip phase:
  - Stimulus: reset, then 6 records with `in_valid`=1 and `out_ready`=1.
  - Response: no `out_valid`; FIFO count stays 0.
- First kept record:
  - Stimulus: the 7th record, xi0=1798, yi0=1179, xb_o=3968, yb_o=1328, other words distinct.
  - Response: 18 words in the order above; idx 16 = 3968; idx 17 = 1328 with `out_last`=1.
- Backpressure:
  - Stimulus: `out_ready` low for 5 cycles at idx 3.
  - Response: `out_data` and `out_idx`=3 stay stable; the stream resumes at idx 4 with no loss or duplication.
- Full and overflow:
  - Stimulus: `out_ready`=0, push 4 kept records, then hold `in_valid` high.
  - Response: `in_ready` low after the 4th push; `ovf`=1; then after `out_ready`=1 for 18 cycles, `in_ready` returns high and the records are read out in order.
- Reset mid-record:
  - Stimulus: `rst_n` low at idx 9 for 2 cycles.
  - Response: all outputs at reset values; the next 6 records after release are discarded.
- Rounding, with `NEWPOINT_ROUND_EN` defined:
  - Stimulus: words 1798 and 1179.
  - Response: output words 112 and 74.

Source files
------------

// File: rtl/newpoint_writer.sv
// Captures point_cal result records, drops warm-up records, buffers them and serializes 18 words each.
// Optional NEWPOINT_ROUND_EN converts each output word to saturated integer pixels (round-half-up).

// state | meaning
// IDLE  | record FIFO empty, no word on the stream
// SEND  | head record presented word by word, index register selects the word
module newpoint_writer #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4,
   parameter int SKIP  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*WIDTH-1:0]   new_xi,
   input  logic [4*WIDTH-1:0]   new_yi,
   input  logic [4*WIDTH-1:0]   new_xo,
   input  logic [4*WIDTH-1:0]   new_yo,
   input  logic [WIDTH-1:0]     xb_o,
   input  logic [WIDTH-1:0]     yb_o,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [4:0]           out_idx,
   output logic                 out_last,
   output logic                 ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   logic [WIDTH-1:0] mem [DEPTH][18];
   logic [WIDTH-1:0] in_words [18];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic [SW-1:0]    skip_cnt;
   logic [4:0]       idx;
   state_t           state;
   logic             keep;
   logic             accept;
   logic             push;
   logic             pop;
   logic             full;
   logic [WIDTH-1:0] head_word;
   logic [WIDTH-1:0] conv_word;

   assign full     = (cnt == CW'(DEPTH));
   assign in_ready = !full;
   assign keep     = (skip_cnt == SW'(SKIP));
   assign accept   = in_valid & in_ready;
   assign push     = accept & keep;
   assign pop      = (state == SEND) & out_ready & (idx == 5'd17);
   assign cnt_next = cnt + CW'(push) - CW'(pop);

   // Word order on the stream: inner pairs, outer pairs, then boundary point.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         in_words[2*k]     = new_xi[k*WIDTH +: WIDTH];
         in_words[2*k+1]   = new_yi[k*WIDTH +: WIDTH];
         in_words[8+2*k]   = new_xo[k*WIDTH +: WIDTH];
         in_words[8+2*k+1] = new_yo[k*WIDTH +: WIDTH];
      end
      in_words[16] = xb_o;
      in_words[17] = yb_o;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int w = 0; w < 18; w++) begin
            mem[wr_ptr][w] <= in_words[w];
         end
      end
   end

   assign head_word = mem[rd_ptr][idx];

`ifdef NEWPOINT_ROUND_EN
   logic [WIDTH:0] rnd_sum;

   always_comb begin
      rnd_sum = ({1'b0, head_word} + (WIDTH+1)'(8)) >> 4;
      if (rnd_sum > (WIDTH+1)'((1 << (WIDTH-4)) - 1)) begin
         conv_word = WIDTH'((1 << (WIDTH-4)) - 1);
      end else begin
         conv_word = rnd_sum[WIDTH-1:0];
      end
   end
`else
   assign conv_word = head_word;
`endif

   assign out_valid = (state == SEND);
   assign out_data  = (state == SEND) ? conv_word : '0;
   assign out_idx   = idx;
   assign out_last  = (idx == 5'd17);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         cnt      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         skip_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (in_valid && !in_ready) ovf <= 1'b1;
         if (accept && !keep) skip_cnt <= skip_cnt + SW'(1);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt_next;
         case (state)
            IDLE: begin
               idx <= '0;
               if (cnt_next != '0) state <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  if (idx == 5'd17) begin
                     idx <= '0;
                     if (cnt_next == '0) state <= IDLE;
                  end else begin
                     idx <= idx + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_newpoint_writer.sv
// Randomized bench for newpoint_writer; a word queue models skip, FIFO order, handshake and ovf.
module tb_newpoint_writer;

   localparam int W = 14;
   localparam int D = 4;
   localparam int S = 6;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [4*W-1:0] new_xi = '0;
   logic [4*W-1:0] new_yi = '0;
   logic [4*W-1:0] new_xo = '0;
   logic [4*W-1:0] new_yo = '0;
   logic [W-1:0]   xb_o = '0;
   logic [W-1:0]   yb_o = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_data;
   logic [4:0]     out_idx;
   logic           out_last;
   logic           ovf;

   int rec [18];
   int wq [$];
   int m_skip;
   bit m_ovf;
   int n_chk;
   int n_pass;

   newpoint_writer #(.WIDTH(W), .DEPTH(D), .SKIP(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .new_xi(new_xi), .new_yi(new_yi), .new_xo(new_xo), .new_yo(new_yo),
      .xb_o(xb_o), .yb_o(yb_o),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic int conv(input int v);
`ifdef NEWPOINT_ROUND_EN
      int r;
      r = (v + 8) / 16;
      if (r > (1 << (W-4)) - 1) r = (1 << (W-4)) - 1;
      return r;
`else
      return v;
`endif
   endfunction

   function automatic int m_recs();
      return (wq.size() + 17) / 18;
   endfunction

   task automatic rand_rec();
      for (int w = 0; w < 18; w++) rec[w] = int'($urandom_range(0, (1 << W) - 1));
   endtask

   task automatic drive_rec();
      for (int k = 0; k < 4; k++) begin
         new_xi[k*W +: W] = W'(rec[2*k]);
         new_yi[k*W +: W] = W'(rec[2*k+1]);
         new_xo[k*W +: W] = W'(rec[8+2*k]);
         new_yo[k*W +: W] = W'(rec[8+2*k+1]);
      end
      xb_o = W'(rec[16]);
      yb_o = W'(rec[17]);
   endtask

   task automatic check_outputs();
      int rem;
      chk("in_ready", in_ready, m_recs() < D);
      chk("out_valid", out_valid, wq.size() > 0);
      chk("ovf", ovf, m_ovf);
      if (wq.size() > 0) begin
         rem = wq.size() % 18;
         if (rem == 0) rem = 18;
         chk("out_data", out_data, wq[0]);
         chk("out_idx", out_idx, 18 - rem);
         chk("out_last", out_last, rem == 1);
      end else begin
         chk("idle_data", out_data, 0);
         chk("idle_idx", out_idx, 0);
      end
   endtask

   // Called just after a rising edge; models the effect of the next edge, then checks after it.
   task automatic cycle(input logic iv, input logic ordy);
      bit rdy;
      bit vld;
      in_valid  = iv;
      out_ready = ordy;
      drive_rec();
      rdy = (m_recs() < D);
      vld = (wq.size() > 0);
      if (iv && !rdy) m_ovf = 1'b1;
      if (vld && ordy) void'(wq.pop_front());
      if (iv && rdy) begin
         if (m_skip < S) m_skip++;
         else for (int w = 0; w < 18; w++) wq.push_back(conv(rec[w]));
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_ovf", ovf, 0);
      wq.delete();
      m_skip = 0;
      m_ovf = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      bit found;
      n_chk = 0;
      n_pass = 0;
      rand_rec();
      #2;
      do_reset();

      for (int i = 0; i < S; i++) begin
         rand_rec();
         cycle(1'b1, 1'b1);
      end

      for (int w = 0; w < 18; w++) rec[w] = 200 + 37 * w;
      rec[0] = 1798; rec[1] = 1179; rec[16] = 3968; rec[17] = 1328;
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1);

      for (int i = 0; i < D; i++) begin
         rand_rec();
         cycle(1'b1, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         rand_rec();
         cycle(1'b1, 1'b0);
      end
      for (int i = 0; i < 18 * D + 4; i++) cycle(1'b0, 1'b1);

      for (int i = 0; i < 600; i++) begin
         rand_rec();
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 18 * D + 4; i++) cycle(1'b0, 1'b1);

      rand_rec();
      cycle(1'b1, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (out_idx == 5'd9) found = 1'b1;
         else cycle(1'b0, 1'b1);
      end
      chk("reach_idx9", found, 1);
      do_reset();

      for (int i = 0; i < S; i++) begin
         rand_rec();
         cycle(1'b1, 1'b1);
      end
      for (int i = 0; i < 200; i++) begin
         rand_rec();
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 18 * D + 4; i++) cycle(1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
